input_conditioner: RTL and testbench



---
 rtl/input_conditioner_pkg.sv | 15 +
 rtl/input_conditioner_if.sv | 24 ++
 rtl/input_conditioner_key_debounce.sv | 118 +++++++++++
 rtl/input_conditioner.sv | 82 ++++++++
 tb/tb_input_conditioner.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared types and DE2 (50 MHz) timing defaults for the input conditioner.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_PRESS_WAIT,
    KS_PRESSED,
    KS_RELEASE_WAIT
  } key_state_e;

  // 20 ms debounce and 250 ms auto-repeat at 50 MHz.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 12_500_000;

endpackage

// File: rtl/input_conditioner_if.sv
// Pin-side and game-side signals of the input conditioner.
interface input_conditioner_if #(
  parameter int unsigned NKEYS = 2,
  parameter int unsigned NSW   = 16
);

  logic [NKEYS-1:0] KEY_N;
  logic [NSW-1:0]   SW_RAW;
  logic [NKEYS-1:0] KEY_PRESS;
  logic [NKEYS-1:0] KEY_LEVEL;
  logic [NSW-1:0]   SW_SYNC;
  logic             SW_CHANGED;

  modport master (
    output KEY_N, SW_RAW,
    input  KEY_PRESS, KEY_LEVEL, SW_SYNC, SW_CHANGED
  );

  modport slave (
    input  KEY_N, SW_RAW,
    output KEY_PRESS, KEY_LEVEL, SW_SYNC, SW_CHANGED
  );

endinterface

// File: rtl/input_conditioner_key_debounce.sv
// Synchroniser, debounce FSM and press pulse for one active-low pushbutton.
// KEY_AUTOREPEAT_EN adds a repeat pulse every REPEAT_CYCLES while held.
module key_debounce
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_press,
  output logic key_level
);

  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || 64'(DEBOUNCE_CYCLES - 1) >= (64'(1) << CNT_W)) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
  end
`ifdef KEY_AUTOREPEAT_EN
  if (REPEAT_CYCLES < 2 || 64'(REPEAT_CYCLES - 1) >= (64'(1) << CNT_W)) begin : g_bad_rp
    $error("REPEAT_CYCLES must be >= 2 and fit in CNT_W bits");
  end
`else
  if (REPEAT_CYCLES < 2) begin : g_bad_rp
    $error("REPEAT_CYCLES must be >= 2");
  end
`endif

  logic [1:0]       sync_q;
  logic             key_low;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  assign key_low = ~sync_q[1];

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RpLast = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rpt_q, rpt_d;

  always_ff @(posedge clk) begin
    if (rst) rpt_q <= '0;
    else     rpt_q <= rpt_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= KS_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    rpt_d   = '0;
`endif
    case (state_q)
      KS_IDLE: begin
        if (key_low) begin
          state_d = KS_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      KS_PRESS_WAIT: begin
        if (!key_low) begin
          state_d = KS_IDLE;
        end else if (cnt_q == DbLast) begin
          state_d = KS_PRESSED;
          press_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      KS_PRESSED: begin
        if (!key_low) begin
          state_d = KS_RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (rpt_q == RpLast) begin
          press_d = 1'b1;
        end else begin
          rpt_d = rpt_q + CNT_W'(1);
        end
`endif
      end
      KS_RELEASE_WAIT: begin
        // Returning low here is bounce on release, not a new press.
        if (key_low) begin
          state_d = KS_PRESSED;
        end else if (cnt_q == DbLast) begin
          state_d = KS_IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = KS_IDLE;
    endcase
  end

  assign key_press = press_q;
  assign key_level = (state_q == KS_PRESSED) || (state_q == KS_RELEASE_WAIT);

endmodule

// File: rtl/input_conditioner.sv
// DE2 pushbutton/switch front end: per-key debounce plus whole-vector switch debounce.
// Define KEY_AUTOREPEAT_EN to enable key auto-repeat.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned NKEYS           = 2,
  parameter int unsigned NSW             = 16,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input logic                CLK,
  input logic                RST,
  input_conditioner_if.slave bus
);

  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NKEYS-1:0] key_press;
  logic [NKEYS-1:0] key_level;

  for (genvar k = 0; k < NKEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_key (
      .clk       (CLK),
      .rst       (RST),
      .key_n     (bus.KEY_N[k]),
      .key_press (key_press[k]),
      .key_level (key_level[k])
    );
  end

  logic [NSW-1:0]   sw_s1_q, sw_s2_q, sw_last_q;
  logic [NSW-1:0]   sw_sync_q, sw_sync_d;
  logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
  logic             sw_chg_q, sw_chg_d;
  logic             sw_stable;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      sw_last_q <= '0;
      sw_cnt_q  <= '0;
      sw_sync_q <= '0;
      sw_chg_q  <= 1'b0;
    end else begin
      sw_s1_q   <= bus.SW_RAW;
      sw_s2_q   <= sw_s1_q;
      sw_last_q <= sw_s2_q;
      sw_cnt_q  <= sw_cnt_d;
      sw_sync_q <= sw_sync_d;
      sw_chg_q  <= sw_chg_d;
    end
  end

  // Any bit change in the synced vector restarts the stability count.
  always_comb begin
    sw_stable = (sw_s2_q == sw_last_q);
    sw_cnt_d  = sw_cnt_q;
    sw_sync_d = sw_sync_q;
    sw_chg_d  = 1'b0;
    if (!sw_stable) begin
      sw_cnt_d = '0;
    end else if (sw_cnt_q != '1) begin
      sw_cnt_d = sw_cnt_q + CNT_W'(1);
    end
    if (sw_stable && (sw_cnt_q == DbLast) && (sw_s2_q != sw_sync_q)) begin
      sw_sync_d = sw_s2_q;
      sw_chg_d  = 1'b1;
    end
  end

  assign bus.KEY_PRESS  = key_press;
  assign bus.KEY_LEVEL  = key_level;
  assign bus.SW_SYNC    = sw_sync_q;
  assign bus.SW_CHANGED = sw_chg_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: expected pulses are queued at stimulus time.
module tb_input_conditioner;

  localparam int NK = 2;
  localparam int NS = 16;
  localparam int DB = 4;
  localparam int RP = 8;
  localparam int CW = 4;
  localparam int LAT = DB + 3;  // drive-to-visible latency in cycles

  localparam int KIND_KEY0 = 0;
  localparam int KIND_KEY1 = 1;
  localparam int KIND_SW   = 2;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  input_conditioner_if #(.NKEYS(NK), .NSW(NS)) bus ();

  input_conditioner #(
    .NKEYS           (NK),
    .NSW             (NS),
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (CW),
    .REPEAT_CYCLES   (RP)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push_exp(input int c, input int kind, input int val);
    ev_t e;
    e.cyc  = c;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input int val);
    ev_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e.cyc  = -1;
      e.kind = -1;
      e.val  = -1;
    end
    check("pulse_cycle", cyc, e.cyc);
    check("pulse_source", kind, e.kind);
    if (kind == KIND_SW) check("sw_sync_at_pulse", val, e.val);
  endtask

  // Output monitor: every pulse must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      for (int k = 0; k < NK; k++) begin
        if (bus.KEY_PRESS[k]) pop_cmp(k, 0);
      end
      if (bus.SW_CHANGED) pop_cmp(KIND_SW, int'(bus.SW_SYNC));
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge CLK);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_press"}, int'(bus.KEY_PRESS), 0);
    check({tag, "_level"}, int'(bus.KEY_LEVEL), 0);
    check({tag, "_sw_sync"}, int'(bus.SW_SYNC), 0);
    check({tag, "_sw_changed"}, int'(bus.SW_CHANGED), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    RST        = 1'b1;
    bus.KEY_N  = '1;
    bus.SW_RAW = '0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    // Clean press and release on key 1.
    c = cyc;
    bus.KEY_N[1] = 1'b0;
    push_exp(c + LAT, KIND_KEY1, 0);
    wait_cyc(c + LAT - 1);
    check("clean_level_before", int'(bus.KEY_LEVEL[1]), 0);
    wait_cyc(c + LAT);
    check("clean_level_rise", int'(bus.KEY_LEVEL[1]), 1);
    wait_cyc(c + 20);
    bus.KEY_N[1] = 1'b1;
    c = cyc;
    wait_cyc(c + LAT - 1);
    check("release_level_held", int'(bus.KEY_LEVEL[1]), 1);
    wait_cyc(c + LAT);
    check("release_level_fall", int'(bus.KEY_LEVEL[1]), 0);
    repeat (5) @(negedge CLK);

    // Bouncy press on key 0: only the final low run counts.
    c = cyc;
    bus.KEY_N[0] = 1'b0;
    wait_cyc(c + 2); bus.KEY_N[0] = 1'b1;
    wait_cyc(c + 3); bus.KEY_N[0] = 1'b0;
    wait_cyc(c + 4); bus.KEY_N[0] = 1'b1;
    wait_cyc(c + 5); bus.KEY_N[0] = 1'b0;
    push_exp(c + 5 + LAT, KIND_KEY0, 0);
    wait_cyc(c + 4 + LAT);
    check("bounce_level_before", int'(bus.KEY_LEVEL[0]), 0);
    wait_cyc(c + 5 + LAT);
    check("bounce_level_rise", int'(bus.KEY_LEVEL), 1);
    wait_cyc(c + 20);
    bus.KEY_N[0] = 1'b1;
    repeat (12) @(negedge CLK);
    check("bounce_released", int'(bus.KEY_LEVEL[0]), 0);

    // Short glitch on key 1 must be ignored.
    c = cyc;
    bus.KEY_N[1] = 1'b0;
    wait_cyc(c + 3);
    bus.KEY_N[1] = 1'b1;
    wait_cyc(c + 12);
    check("glitch_level", int'(bus.KEY_LEVEL[1]), 0);

    // Simultaneous presses give simultaneous pulses.
    c = cyc;
    bus.KEY_N = 2'b00;
    push_exp(c + LAT, KIND_KEY0, 0);
    push_exp(c + LAT, KIND_KEY1, 0);
    wait_cyc(c + LAT);
    check("both_level", int'(bus.KEY_LEVEL), 3);
    wait_cyc(c + 15);
    bus.KEY_N = 2'b11;
    repeat (12) @(negedge CLK);
    check("both_released", int'(bus.KEY_LEVEL), 0);

    // Switch vector load, then a short toggle that must not register.
    c = cyc;
    bus.SW_RAW = 16'h00A5;
    push_exp(c + LAT, KIND_SW, 'h00A5);
    wait_cyc(c + LAT - 1);
    check("sw_before", int'(bus.SW_SYNC), 0);
    wait_cyc(c + LAT);
    check("sw_loaded", int'(bus.SW_SYNC), 'h00A5);
    wait_cyc(c + 10);
    bus.SW_RAW = 16'h00AD;
    wait_cyc(c + 12);
    bus.SW_RAW = 16'h00A5;
    wait_cyc(c + 25);
    check("sw_toggle_ignored", int'(bus.SW_SYNC), 'h00A5);
    c = cyc;
    bus.SW_RAW = 16'h1234;
    push_exp(c + LAT, KIND_SW, 'h1234);
    wait_cyc(c + LAT);
    check("sw_second_load", int'(bus.SW_SYNC), 'h1234);
    repeat (3) @(negedge CLK);

    // Reset in KS_PRESS_WAIT with cnt==2; key and switches stay asserted.
    c = cyc;
    bus.KEY_N[1] = 1'b0;
    wait_cyc(c + 5);
    RST = 1'b1;
    @(negedge CLK);
    check_all_zero("midreset");
    RST = 1'b0;
    c = cyc;
    push_exp(c + LAT, KIND_KEY1, 0);
    push_exp(c + LAT, KIND_SW, 'h1234);
    wait_cyc(c + LAT - 1);
    check("postreset_level_before", int'(bus.KEY_LEVEL[1]), 0);
    wait_cyc(c + LAT);
    check("postreset_level_rise", int'(bus.KEY_LEVEL[1]), 1);
    check("postreset_sw", int'(bus.SW_SYNC), 'h1234);
    wait_cyc(c + 15);
    bus.KEY_N[1] = 1'b1;
    repeat (12) @(negedge CLK);

    // Long hold on key 0: one pulse, or a pulse every RP cycles with repeat.
    c = cyc;
    bus.KEY_N[0] = 1'b0;
    push_exp(c + LAT, KIND_KEY0, 0);
`ifdef KEY_AUTOREPEAT_EN
    for (int i = 1; i <= 4; i++) push_exp(c + LAT + i * RP, KIND_KEY0, 0);
`endif
    wait_cyc(c + 40);
    bus.KEY_N[0] = 1'b1;
    repeat (15) @(negedge CLK);
    check("hold_released", int'(bus.KEY_LEVEL[0]), 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
